// File: rtl/sys_timer_x_if.sv
// Register bus between a CPU-side I/O decoder and the system timer.
// Latency: rdata is combinational from adr; writes are captured on the next rising clk edge.
// Backpressure: none; every qualified wr strobe is accepted in the cycle it is presented.
//
// Signals:
//   wr    - register write strobe, already qualified by I/O decode
//   rd    - register read strobe, informational only (reads have no side effects)
//   adr   - 4-bit local word address
//   wdata - 32-bit write data
//   rdata - 32-bit read data
interface sys_timer_x_if;
  logic        wr;
  logic        rd;
  logic [3:0]  adr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output wr,
    output rd,
    output adr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  wr,
    input  rd,
    input  adr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/sys_timer_x.sv
// System timer: prescaled 1/TICK_HZ tick, free-running tick counter and NCH countdown channels with IRQ.
// Latency: register writes take effect on the next edge; PEND sets on the expiry edge, irq follows one cycle later.
// Backpressure: none; the register bus is always ready and reads are side-effect free.
//
// Ports:
//   clk  - single rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - register bus (slave side): wr, rd, adr, wdata in; rdata out
//   tick - one-cycle pulse each time the prescaler reaches its maximum
//   irq  - level interrupt, OR of (PEND & IEN), driven from registers only
//
// Register map (word addresses):
//   0 MS (RO tick counter), 1 PEND (W1C), 2 IEN, 3 reserved,
//   4+2c CTRL(c) {PERIODIC, EN}, 5+2c CNT(c) (write RELOAD, read COUNT)
module sys_timer_x #(
  parameter int CLK_HZ  = 40000000,
  parameter int TICK_HZ = 1000,
  parameter int NCH     = 4,
  parameter int CW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  sys_timer_x_if.slave  bus,
  output logic          tick,
  output logic          irq
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("sys_timer_x: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (NCH < 1 || NCH > 6) begin : g_bad_nch
    $error("sys_timer_x: NCH must be in 1..6");
  end
  if (CW < 8 || CW > 32) begin : g_bad_cw
    $error("sys_timer_x: CW must be in 8..32");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  pre_q,  pre_d;
  logic [31:0]    ms_q,   ms_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ien_q,  ien_d;
  logic [NCH-1:0] en_q,   en_d;
  logic [NCH-1:0] per_q,  per_d;
  logic [CW-1:0]  reload_q [NCH];
  logic [CW-1:0]  reload_d [NCH];
  logic [CW-1:0]  count_q  [NCH];
  logic [CW-1:0]  count_d  [NCH];

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic           wr_pend;
  logic           wr_ien;
  logic [NCH-1:0] wr_ctrl;
  logic [NCH-1:0] wr_cnt;
  logic [NCH-1:0] expire;

  always_comb begin
    wr_pend = bus.wr && (bus.adr == 4'd1);
    wr_ien  = bus.wr && (bus.adr == 4'd2);
    wr_ctrl = '0;
    wr_cnt  = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_ctrl[c] = bus.wr && (bus.adr == 4'(4 + 2 * c));
      wr_cnt[c]  = bus.wr && (bus.adr == 4'(5 + 2 * c));
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and tick counter
  // ---------------------------------------------------------------------------
  assign tick = (pre_q == PW'(DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    ms_d  = tick ? ms_q + 32'd1 : ms_q;
  end

  // ---------------------------------------------------------------------------
  // Countdown channels
  // ---------------------------------------------------------------------------
  always_comb begin
    en_d   = en_q;
    per_d  = per_q;
    expire = '0;
    for (int c = 0; c < NCH; c++) begin
      reload_d[c] = reload_q[c];
      count_d[c]  = count_q[c];

      // A new RELOAD never touches a running COUNT; it is picked up at the
      // next expiry reload or the next CTRL write with EN=1.
      if (wr_cnt[c]) begin
        reload_d[c] = bus.wdata[CW-1:0];
      end

      // CTRL writes win over tick processing for the same channel.
      if (wr_ctrl[c]) begin
        per_d[c] = bus.wdata[1];
        if (bus.wdata[0]) begin
          count_d[c] = reload_q[c];
          // A zero reload would expire immediately; refuse to start instead.
          en_d[c]    = (reload_q[c] != '0);
        end else begin
          en_d[c]    = 1'b0;
        end
      end else if (tick && en_q[c]) begin
        if (count_q[c] <= CW'(1)) begin
          expire[c] = 1'b1;
          // RELOAD may have been rewritten to 0 while running; stop rather
          // than restart with a count that can never expire cleanly.
          if (per_q[c] && (reload_q[c] != '0)) begin
            count_d[c] = reload_q[c];
          end else begin
            count_d[c] = '0;
            en_d[c]    = 1'b0;
          end
        end else begin
          count_d[c] = count_q[c] - CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / enable
  // ---------------------------------------------------------------------------
  always_comb begin
    // Expiry is OR-ed in after the clear so a same-cycle W1C cannot lose it.
    pend_d = (pend_q & ~(wr_pend ? bus.wdata[NCH-1:0] : '0)) | expire;
    ien_d  = wr_ien ? bus.wdata[NCH-1:0] : ien_q;
  end

  assign irq = |(pend_q & ien_q);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      ms_q   <= '0;
      pend_q <= '0;
      ien_q  <= '0;
      en_q   <= '0;
      per_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        reload_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      ms_q   <= ms_d;
      pend_q <= pend_d;
      ien_q  <= ien_d;
      en_q   <= en_d;
      per_q  <= per_d;
      for (int c = 0; c < NCH; c++) begin
        reload_q[c] <= reload_d[c];
        count_q[c]  <= count_d[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: combinational from adr, unused bits and unmapped addresses read 0
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_v;

  always_comb begin
    rdata_v = '0;
    case (bus.adr)
      4'd0:    rdata_v = ms_q;
      4'd1:    rdata_v[NCH-1:0] = pend_q;
      4'd2:    rdata_v[NCH-1:0] = ien_q;
      4'd3:    rdata_v = '0;
      default: begin
        for (int c = 0; c < NCH; c++) begin
          if (bus.adr == 4'(4 + 2 * c)) begin
            rdata_v[1:0] = {per_q[c], en_q[c]};
          end
          if (bus.adr == 4'(5 + 2 * c)) begin
            rdata_v[CW-1:0] = count_q[c];
          end
        end
      end
    endcase
  end

  assign bus.rdata = rdata_v;

  // rd only marks a bus read cycle; reads have no side effects. Upper wdata
  // bits are don't-care for every register.
  logic unused_bus;
  assign unused_bus = bus.rd ^ (^bus.wdata);

endmodule

// File: doc/sys_timer_x.md
SYS_TIMER_X -- requirements
Module: sys_timer_x

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- CLK_HZ, 40000000, input clock frequency.
- TICK_HZ, 1000, tick rate; CLK_HZ/TICK_HZ SHALL be an integer ≥ 2.
- NCH, 4, number of countdown channels, legal range 1..6.
- CW, 32, channel counter and reload width, legal range 8..32.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state SHALL be on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- wr, in, 1, register write strobe, already qualified by I/O decode.
- rd, in, 1, register read strobe, for information only.
- adr, in, 4, local word address.
- wdata, in, 32, write data.
- rdata, out, 32, read data, combinational from adr.
- tick, out, 1, one-cycle pulse at TICK_HZ; replaces the legacy limit.
- irq, out, 1, interrupt request, level.

Function
REQ-003 The register map SHALL be:
- 0 MS: read-only tick counter.
- 1 PEND: read returns pending bits; write-1-to-clear.
- 2 IEN: read/write interrupt enables, width NCH.
- 3 reserved: reads 0.
- 4+2c CTRL(c): bit0 EN, bit1 PERIODIC.
- 5+2c CNT(c): write sets RELOAD(c); read returns COUNT(c).
REQ-004 Addresses beyond 5+2(NCH-1) SHALL read 0, and writes to them SHALL be ignored.
REQ-005 Unused upper rdata bits SHALL read 0.
REQ-006 The prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and wrap to 0.
REQ-007 tick SHALL be 1 exactly in the cycle the prescaler equals its maximum.
REQ-008 MS SHALL increment by 1 in each tick cycle and wrap from 0xFFFFFFFF to 0.
REQ-009 A CTRL(c) write with EN=1 SHALL load COUNT(c)=RELOAD(c) on that edge, independent of the previous EN.
REQ-010 A CTRL(c) write with EN=0 SHALL stop the channel and leave COUNT(c) unchanged.
REQ-011 A CTRL(c) write with EN=1 and RELOAD(c)=0 SHALL leave EN=0 and set no PEND bit.
REQ-012 While EN(c)=1, each tick cycle SHALL decrement COUNT(c) by 1.
REQ-013 In a tick cycle with EN(c)=1 and COUNT(c)=1, PEND(c) SHALL be set (expiry).
REQ-014 On expiry with PERIODIC=1, COUNT(c) SHALL be loaded with RELOAD(c), giving an exact period of RELOAD ticks.
REQ-015 On expiry with PERIODIC=0 (one-shot), COUNT(c) SHALL become 0 and EN(c) SHALL be cleared.
REQ-016 A CTRL(c) write SHALL take priority over tick processing for channel c in the same cycle.
REQ-017 Expiry and a PEND write-1-clear of the same bit in the same cycle SHALL leave the bit set.
REQ-018 A RELOAD write while running SHALL not alter COUNT; it SHALL take effect at the next reload or EN write.
REQ-019 irq SHALL equal the OR of (PEND & IEN), derived from registers only, with no combinational path from wr or wdata.
REQ-020 irq SHALL rise in the cycle after the expiry edge.
REQ-021 Reads SHALL have no side effects.
REQ-022 RELOAD and COUNT SHALL be CW bits wide, with writes taking wdata[CW-1:0].

Reset
REQ-023 While rst=1, all of the following SHALL be 0: prescaler, MS, PEND, IEN, EN, PERIODIC, RELOAD and COUNT for every channel, tick, and irq.
REQ-024 A reset asserted mid-countdown SHALL abort the countdown with no PEND set.
REQ-025 The first tick after rst deasserts SHALL occur CLK_HZ/TICK_HZ cycles after the first active edge.

Verification
(All scenarios use CLK_HZ=8, TICK_HZ=1, NCH=4, CW=16.)
REQ-026 Free-run 80 cycles after reset -> tick pulses every 8 cycles, and MS reads 10.
REQ-027 Set RELOAD(0)=3, IEN=1, CTRL(0)=3 (periodic) -> PEND[0] and irq rise after 3 ticks; write PEND=1 to clear; PEND[0] sets again exactly 3 ticks after the previous expiry.
REQ-028 Set RELOAD(2)=2, CTRL(2)=1 (one-shot) -> PEND[2]=1 after 2 ticks, CTRL(2) reads 0, CNT(2) reads 0, and no further expiry within 10 ticks.
REQ-029 Write PEND=0x2 in the exact expiry cycle of channel 1 -> PEND[1] remains 1.
REQ-030 CTRL(3)=1 with RELOAD(3)=0 -> EN reads 0 and PEND[3] stays 0; then assert rst during a RELOAD=5 countdown -> all registers read 0 and irq=0.
